// File: rtl/cc_event_pkg.sv
// Shared types and defaults for the cross-clock event feeder.
package cc_event_pkg;

  localparam int unsigned CC_CNT_W_DEF     = 4;
  localparam int unsigned CC_GUARD_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } cc_feed_state_t;

endpackage

// File: rtl/cc_event_feeder_if.sv
// Source-side event / handshake signal bundle for cc_event_feeder.
interface cc_event_feeder_if
  import cc_event_pkg::*;
#(
  parameter int unsigned CNT_W = CC_CNT_W_DEF
);

  logic             ev_in;
  logic             ovf_clr;
  logic             cc_busy;
  logic             cc_in;
  logic [CNT_W-1:0] pending;
  logic             ovf;
  logic             idle;

  modport master (
    output ev_in, ovf_clr, cc_busy,
    input  cc_in, pending, ovf, idle
  );

  modport slave (
    input  ev_in, ovf_clr, cc_busy,
    output cc_in, pending, ovf, idle
  );

endinterface

// File: rtl/cc_sat_updown_cnt.sv
// Saturating up/down counter; an increment at full is reported on drop.
module cc_sat_updown_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         drop
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == CNT_MAX);
  assign drop = inc && !dec && full;
  assign cnt  = cnt_q;

  // Simultaneous inc/dec cancels; never wraps in either direction.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cc_event_feeder.sv
// Queues source-domain event pulses and feeds them one at a time into the
// cross-clock event handshake, waiting out its busy phase between fires.
module cc_event_feeder
  import cc_event_pkg::*;
#(
  parameter int unsigned CNT_W     = CC_CNT_W_DEF,
  parameter int unsigned GUARD_CYC = CC_GUARD_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  cc_event_feeder_if.slave   bus
);

  localparam int unsigned GRD_W = $clog2(GUARD_CYC + 1);

  cc_feed_state_t   state_q, state_d;
  logic [GRD_W-1:0] guard_q, guard_d;
  logic             cc_in_q, cc_in_d;
  logic             ovf_q, ovf_d;
  logic             idle_q, idle_d;

  logic [CNT_W-1:0] cnt;
  logic             unused_full;
  logic             drop;
  logic             fire;
  logic             pend_nz;
  logic             bypass;
  logic             consume;
  logic             accept;
  logic             cnt_zero_d;

  assign pend_nz = (cnt != '0);
  assign bypass  = fire && !pend_nz;
  assign consume = fire && pend_nz;
  assign accept  = bus.ev_in && !bypass;

  cc_sat_updown_cnt #(
    .W (CNT_W)
  ) u_pend_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .dec   (consume),
    .cnt   (cnt),
    .full  (unused_full),
    .drop  (drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the guard timeout covers a handshake that finished unseen.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.cc_busy && (pend_nz || bus.ev_in)) begin
          fire    = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.cc_busy || ((guard_q + GRD_W'(1)) >= GRD_W'(GUARD_CYC))) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.cc_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values; a new drop outranks ovf_clr.
  always_comb begin
    cc_in_d    = fire;
    guard_d    = '0;
    ovf_d      = ovf_q;
    cnt_zero_d = 1'b0;
    idle_d     = 1'b0;
    if ((state_q == WAIT_HI) && (state_d == WAIT_HI)) begin
      guard_d = guard_q + GRD_W'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    cnt_zero_d = ((cnt == '0) && !accept) ||
                 ((cnt == CNT_W'(1)) && consume && !accept);
    idle_d     = (state_d == IDLE) && cnt_zero_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      guard_q <= '0;
      cc_in_q <= 1'b0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      guard_q <= guard_d;
      cc_in_q <= cc_in_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.cc_in   = cc_in_q;
  assign bus.pending = cnt;
  assign bus.ovf     = ovf_q;
  assign bus.idle    = idle_q;

endmodule

// File: tb/tb_cc_event_feeder.sv
// Scoreboard bench for cc_event_feeder: two instances (CNT_W=4 and CNT_W=2)
// each driven against a simple busy-pulse model of the downstream handshake.
module tb_cc_event_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic en_a, en_b;
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   q_a[$];
  int   q_b[$];
  int unsigned bcnt_a = 0;
  int unsigned bcnt_b = 0;

  cc_event_feeder_if #(.CNT_W(4)) bus_a ();
  cc_event_feeder_if #(.CNT_W(2)) bus_b ();

  cc_event_feeder #(.CNT_W(4), .GUARD_CYC(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a.slave)
  );

  cc_event_feeder #(.CNT_W(2), .GUARD_CYC(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b.slave)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  // Handshake model: busy rises the cycle after cc_in and lasts 6 cycles.
  always @(posedge clk) begin
    if (!en_a)                bcnt_a <= 0;
    else if (bus_a.cc_in)     bcnt_a <= 6;
    else if (bcnt_a != 0)     bcnt_a <= bcnt_a - 1;
    if (!en_b)                bcnt_b <= 0;
    else if (bus_b.cc_in)     bcnt_b <= 6;
    else if (bcnt_b != 0)     bcnt_b <= bcnt_b - 1;
  end
  assign bus_a.cc_busy = (bcnt_a != 0);
  assign bus_b.cc_busy = (bcnt_b != 0);

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse monitor: each cc_in pulse pops its expected firing edge.
  logic pa_busy = 1'b0, pa_cc = 1'b0, pb_busy = 1'b0, pb_cc = 1'b0;
  always @(negedge clk) begin
    int e;
    if (bus_a.cc_in) begin
      chk("a_pulse_rule", int'(pa_busy | pa_cc), 0);
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_pulse: unexpected pulse at edge %0d, none expected", edge_n);
      end else begin
        e = q_a.pop_front();
        chk("a_pulse_edge", edge_n, e);
      end
    end
    if (bus_b.cc_in) begin
      chk("b_pulse_rule", int'(pb_busy | pb_cc), 0);
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_pulse: unexpected pulse at edge %0d, none expected", edge_n);
      end else begin
        e = q_b.pop_front();
        chk("b_pulse_edge", edge_n, e);
      end
    end
    pa_busy = bus_a.cc_busy; pa_cc = bus_a.cc_in;
    pb_busy = bus_b.cc_busy; pb_cc = bus_b.cc_in;
  end

  initial begin
    int b;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    bus_a.ev_in = 1'b0; bus_a.ovf_clr = 1'b0;
    bus_b.ev_in = 1'b0; bus_b.ovf_clr = 1'b0;
    step(3);
    chk("a_rst_cc_in",   int'(bus_a.cc_in),   0);
    chk("a_rst_pending", int'(bus_a.pending), 0);
    chk("a_rst_ovf",     int'(bus_a.ovf),     0);
    chk("a_rst_idle",    int'(bus_a.idle),    1);
    chk("b_rst_cc_in",   int'(bus_b.cc_in),   0);
    chk("b_rst_pending", int'(bus_b.pending), 0);
    chk("b_rst_ovf",     int'(bus_b.ovf),     0);
    chk("b_rst_idle",    int'(bus_b.idle),    1);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    step(6);

    // Single event sampled at edge 10, bypassing the queue.
    b = edge_n;
    bus_a.ev_in = 1'b1; q_a.push_back(b + 1);
    step(1);
    bus_a.ev_in = 1'b0;
    chk("single_cc_in_hi", int'(bus_a.cc_in),   1);
    chk("single_pending",  int'(bus_a.pending), 0);
    step(1);
    chk("single_cc_in_lo", int'(bus_a.cc_in),   0);
    step(3);
    chk("single_busy_idle", int'(bus_a.idle),   0);
    step(4);
    chk("single_idle_back", int'(bus_a.idle),   1);
    step(3);

    // Five-cycle burst: one bypass, four queued, nine-cycle fire spacing.
    b = edge_n;
    bus_a.ev_in = 1'b1;
    for (int i = 0; i < 5; i++) q_a.push_back(b + 1 + 9 * i);
    step(1);
    chk("burst_bypass_pend", int'(bus_a.pending), 0);
    step(4);
    bus_a.ev_in = 1'b0;
    chk("burst_peak",        int'(bus_a.pending), 4);
    step(4);
    chk("burst_hold",        int'(bus_a.pending), 4);
    step(1);
    chk("burst_first_pop",   int'(bus_a.pending), 3);
    step(27);
    chk("burst_drained",     int'(bus_a.pending), 0);
    step(10);
    chk("burst_ovf",         int'(bus_a.ovf),     0);
    chk("burst_idle",        int'(bus_a.idle),    1);

    // Busy never rises: guard timeout gives six-cycle spacing.
    en_a = 1'b0;
    step(1);
    b = edge_n;
    bus_a.ev_in = 1'b1;
    for (int i = 0; i < 4; i++) q_a.push_back(b + 1 + 6 * i);
    step(4);
    bus_a.ev_in = 1'b0;
    chk("guard_queued",  int'(bus_a.pending), 3);
    step(3);
    chk("guard_pop",     int'(bus_a.pending), 2);
    step(12);
    chk("guard_drained", int'(bus_a.pending), 0);
    step(4);
    chk("guard_wait_lo", int'(bus_a.idle),    0);
    step(2);
    chk("guard_idle",    int'(bus_a.idle),    1);
    en_a = 1'b1;
    step(2);

    // Reset mid-flight with three queued events and busy high.
    b = edge_n;
    bus_a.ev_in = 1'b1; q_a.push_back(b + 1);
    step(4);
    chk("rst_pre_pending", int'(bus_a.pending), 3);
    bus_a.ev_in = 1'b0;
    rst_a_n = 1'b0;
    step(1);
    chk("rst_mid_cc_in",   int'(bus_a.cc_in),   0);
    chk("rst_mid_pending", int'(bus_a.pending), 0);
    chk("rst_mid_ovf",     int'(bus_a.ovf),     0);
    chk("rst_mid_idle",    int'(bus_a.idle),    1);
    rst_a_n = 1'b1;
    bus_a.ev_in = 1'b1; q_a.push_back(b + 9);
    step(1);
    bus_a.ev_in = 1'b0;
    chk("rst_post_queued", int'(bus_a.pending), 1);
    chk("rst_post_no_fire", int'(bus_a.cc_in),  0);
    step(3);
    chk("rst_post_fired",  int'(bus_a.pending), 0);
    step(12);

    // Overflow on the 2-bit instance; set wins over a same-cycle clear.
    b = edge_n;
    bus_b.ev_in = 1'b1;
    for (int i = 0; i < 4; i++) q_b.push_back(b + 1 + 9 * i);
    step(4);
    chk("ovf_sat_pending", int'(bus_b.pending), 3);
    chk("ovf_not_yet",     int'(bus_b.ovf),     0);
    step(1);
    chk("ovf_set",         int'(bus_b.ovf),     1);
    chk("ovf_pending_hold", int'(bus_b.pending), 3);
    step(1);
    bus_b.ovf_clr = 1'b1;
    step(1);
    bus_b.ev_in = 1'b0;
    chk("ovf_set_wins",    int'(bus_b.ovf),     1);
    chk("ovf_pend_still",  int'(bus_b.pending), 3);
    step(1);
    bus_b.ovf_clr = 1'b0;
    chk("ovf_cleared",     int'(bus_b.ovf),     0);
    step(2);
    chk("ovf_first_pop",   int'(bus_b.pending), 2);
    step(18);
    chk("ovf_drained",     int'(bus_b.pending), 0);
    step(10);
    chk("ovf_idle",        int'(bus_b.idle),    1);

    // Full queue, IDLE, busy low, ev_in high: accept and consume cancel.
    b = edge_n;
    bus_b.ev_in = 1'b1; q_b.push_back(b + 1);
    step(4);
    bus_b.ev_in = 1'b0;
    chk("full_setup",      int'(bus_b.pending), 3);
    step(5);
    bus_b.ev_in = 1'b1;
    for (int i = 0; i < 4; i++) q_b.push_back(b + 10 + 9 * i);
    step(1);
    bus_b.ev_in = 1'b0;
    chk("full_same_pend",  int'(bus_b.pending), 3);
    chk("full_same_ovf",   int'(bus_b.ovf),     0);
    chk("full_same_cc_in", int'(bus_b.cc_in),   1);
    step(27);
    chk("full_drained",    int'(bus_b.pending), 0);
    step(10);

    chk("a_pulses_left", q_a.size(), 0);
    chk("b_pulses_left", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cc_event_feeder.md
# cc_event_feeder

Source-domain front end for the cross-clock event handshake. Accepts single-cycle event pulses at any rate and queues them as a saturating pending count. Issues them one at a time as single-cycle pulses into the handshake's event input, never firing while the handshake reports busy. This gives the source side lossless, rate-decoupled event transfer up to the queue depth, plus overflow reporting beyond it.

## Interface
- `CNT_W`, default 4: pending-counter width; queue depth is 2^CNT_W−1 events.
- `GUARD_CYC`, default 4: maximum cycles to wait for `cc_busy` to rise after a fire before treating the handshake as already complete; legal range ≥1.
- `clk`  in  1  source-domain clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ev_in`  in  1  event request; each cycle sampled high counts as one event.
- `ovf_clr`  in  1  clears the sticky `ovf` flag.
- `cc_busy`  in  1  busy output of the downstream cross-clock event handshake.
- `cc_in`  out  1  registered single-cycle event pulse to the handshake.
- `pending`  out  CNT_W  events queued and not yet issued; excludes an event currently in flight.
- `ovf`  out  1  sticky flag; set when an event is dropped because the queue is full.
- `idle`  out  1  high when the FSM is in IDLE and `pending`==0.

## Operation
- FSM states: IDLE, WAIT_HI, WAIT_LO. State is encoded as a package enum.
- IDLE, fire condition: fire when `cc_busy`==0 and (`pending`>0 or `ev_in`==1).
  - On fire: `cc_in`<=1 and state<=WAIT_HI.
  - If `pending`==0, the event on `ev_in` is issued directly (bypass) and `pending` stays 0.
- WAIT_HI: `cc_in`<=0 and the guard counter increments.
  - `cc_busy`==1 → go to WAIT_LO.
  - Guard reaches GUARD_CYC with `cc_busy` still low → go to WAIT_LO. The handshake is treated as having completed already.
  - The guard counter clears on entry.
- WAIT_LO: `cc_busy`==0 → go to IDLE. Otherwise stay.
- Pending update, applied every cycle: `pending` += accept − consume.
  - accept = `ev_in` and not bypassed.
  - consume = fire taken from the queue (`pending`>0).
  - Accept and consume in the same cycle → `pending` is unchanged.
- Full: `pending`==2^CNT_W−1 and accept without consume → event dropped, `pending` holds, `ovf`<=1.
- Full with simultaneous consume → event accepted and `pending` unchanged; no overflow.
- `ovf_clr` and a new drop in the same cycle → `ovf` stays 1 (set wins).
- `cc_in` is never asserted while the sampled `cc_busy`==1, and never in two consecutive cycles.

## Timing
- Reset values: `cc_in`=0, `pending`=0, `ovf`=0, `idle`=1, state=IDLE, guard=0.
- Latency: `ev_in` sampled at edge k in an eligible IDLE → `cc_in` high from edge k to edge k+1, i.e. 1 cycle.
- Minimum fire spacing is 3 cycles: fire k, WAIT_HI k+1, WAIT_LO k+2, IDLE fire at k+3 if `cc_busy` fell.
- `pending` and `ovf` are registered and reflect edge k's inputs after edge k.
- Reset asserted mid-operation: all state clears at the next edge and queued events are lost. After reset, IDLE waits for `cc_busy`==0 before firing, so a handshake left in flight is respected.
- `cc_busy` is a synchronous input in `clk`'s domain, as produced by the handshake.

## Structure
- Package `cc_event_pkg`:
  - `cc_feed_state_t` enum (IDLE, WAIT_HI, WAIT_LO).
  - Default `CNT_W`/`GUARD_CYC` localparams.
- One sub-module, `cc_sat_updown_cnt` (parameter W): `inc`, `dec`, `cnt`, `full`, `drop`. Simultaneous inc/dec is a no-op; inc at full asserts `drop`.
- Top-level `cc_event_feeder` holds the FSM, guard counter, `ovf` flag and output registers.

## Test plan
Bench conditions: clk period 10 ns; the handshake is modelled with `cc_busy` rising 1 cycle after `cc_in` and lasting 6 cycles unless stated.
- Single event, idle start → `ev_in` 1 cycle at edge 10: `cc_in` high only edge 10–11; `pending` stays 0; `idle` returns 1 after `cc_busy` falls.
- Burst → `ev_in` high 5 consecutive cycles:
  - `pending` peaks at 4.
  - Exactly 5 `cc_in` pulses, each issued only after `cc_busy` fell.
  - Final `pending`=0 and `ovf`=0.
- Overflow with `CNT_W`=2 → 6-cycle burst:
  - First event bypassed; `pending` saturates at 3; 2 events dropped.
  - `ovf`=1 and 4 pulses total.
  - `ovf_clr` together with a further drop in the same cycle: `ovf` stays 1.
- Busy never rises → `cc_busy` tied 0 with `GUARD_CYC`=4:
  - Each fire is followed by exactly 4 WAIT_HI cycles, then WAIT_LO→IDLE.
  - 3 queued events are issued with 6-cycle spacing.
- Reset mid-flight → `rst_n` low 1 cycle while `pending`=3 and `cc_busy`=1:
  - Next cycle all outputs are at reset values.
  - The next `ev_in` fires only after `cc_busy` drops.
- Simultaneous accept/consume at full (`pending`=2^CNT_W−1, IDLE, `cc_busy`=0, `ev_in`=1) → `pending` unchanged, `ovf` stays 0, `cc_in`=1.
